// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller: drives three digits (opa, opb, sum) through one shared
// segment decoder, with a blank phase before each digit and tear-free frame updates.
module seg_scan_ctrl #(
  parameter int unsigned DATA_WIDTH   = 3,
  parameter int unsigned RESULT_WIDTH = 7,
  parameter int unsigned PRESCALE     = 16,
  parameter int unsigned BLANK_CYCLES = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    load,
  input  logic [DATA_WIDTH-1:0]   opa,
  input  logic [DATA_WIDTH-1:0]   opb,
  input  logic [DATA_WIDTH-1:0]   sum,
  output logic [DATA_WIDTH-1:0]   dec_in,
  input  logic [RESULT_WIDTH-1:0] dec_out,
  output logic [RESULT_WIDTH-1:0] seg_out,
  output logic [2:0]              digit_sel,
  output logic                    frame_done
);

  localparam int unsigned CNT_MAX   = (PRESCALE > BLANK_CYCLES) ? PRESCALE : BLANK_CYCLES;
  localparam int unsigned CNT_W     = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam bit          HAS_BLANK = (BLANK_CYCLES != 0);

  localparam logic [CNT_W-1:0] ACT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] BLK_LAST = CNT_W'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StBlank, StActive} state_e;

  // Phase entered at the start of every digit slot.
  localparam state_e StSlot = HAS_BLANK ? StBlank : StActive;

  state_e                state_q, state_d;
  logic [1:0]            idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] stg_q  [3];
  logic [DATA_WIDTH-1:0] stg_d  [3];
  logic [DATA_WIDTH-1:0] disp_q [3];
  logic [DATA_WIDTH-1:0] disp_d [3];
  logic [DATA_WIDTH-1:0] load_val [3];
  logic                  wrap;
  logic [1:0]            idx_next;

  assign load_val[0] = opa;
  assign load_val[1] = opb;
  assign load_val[2] = sum;

  // Out-of-range index (never reached normally) falls back to digit 0.
  assign idx_next = (idx_q >= 2'd2) ? 2'd0 : idx_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        stg_q[i]  <= '0;
        disp_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      for (int i = 0; i < 3; i++) begin
        stg_q[i]  <= stg_d[i];
        disp_q[i] <= disp_d[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          state_d = StSlot;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end
      end
      StBlank: begin
        if (!en) begin
          state_d = StIdle;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == BLK_LAST) begin
          state_d = StActive;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StActive: begin
        if (!en) begin
          state_d = StIdle;
          idx_d   = 2'd0;
          cnt_d   = '0;
        end else if (cnt_q == ACT_LAST) begin
          state_d = StSlot;
          cnt_d   = '0;
          idx_d   = idx_next;
          wrap    = (idx_q == 2'd2);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        idx_d   = 2'd0;
        cnt_d   = '0;
      end
    endcase
  end

  // Display only changes while idle or on the frame wrap, so a frame never mixes values.
  always_comb begin
    stg_d  = stg_q;
    disp_d = disp_q;
    pend_d = pend_q;

    if (state_q == StIdle) begin
      disp_d = stg_q;
    end

    if (wrap) begin
      if (pend_q) begin
        disp_d = stg_q;
      end
      pend_d = 1'b0;
    end

    if (load) begin
      stg_d = load_val;
      if (wrap) begin
        disp_d = load_val;
      end else begin
        pend_d = 1'b1;
      end
    end
  end

  always_comb begin
    case (idx_q)
      2'd0:    dec_in = disp_q[0];
      2'd1:    dec_in = disp_q[1];
      2'd2:    dec_in = disp_q[2];
      default: dec_in = '0;
    endcase
  end

  always_comb begin
    seg_out    = '0;
    digit_sel  = 3'b000;
    frame_done = 1'b0;
    if (state_q == StActive) begin
      seg_out = dec_out;
      case (idx_q)
        2'd0:    digit_sel = 3'b001;
        2'd1:    digit_sel = 3'b010;
        2'd2:    digit_sel = 3'b100;
        default: digit_sel = 3'b000;
      endcase
      frame_done = (idx_q == 2'd2) && (cnt_q == ACT_LAST);
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl: two instances (PRESCALE=4/BLANK=1 and
// PRESCALE=1/BLANK=0) checked every cycle against a frame-position reference model.
module tb_seg_scan_ctrl;

  logic       clk;
  logic [1:0] rst;
  logic [1:0] en;
  logic [1:0] ld;
  logic [2:0] opa, opb, sum;

  logic [2:0] dec0, dec1;
  logic [6:0] dout0, dout1;
  logic [6:0] seg0, seg1;
  logic [2:0] sel0, sel1;
  logic       fd0, fd1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: scan position as a cycle count since the scan started.
  int         pp [2] = '{4, 1};
  int         bb [2] = '{1, 0};
  bit         m_run  [2];
  int         m_t    [2];
  bit         m_pend [2];
  logic [2:0] m_disp [2][3];
  logic [2:0] m_stg  [2][3];

  assign dout0 = {4'b0000, dec0};
  assign dout1 = {4'b0000, dec1};

  seg_scan_ctrl #(
    .DATA_WIDTH  (3),
    .RESULT_WIDTH(7),
    .PRESCALE    (4),
    .BLANK_CYCLES(1)
  ) u_dut0 (
    .clk       (clk),
    .rst       (rst[0]),
    .en        (en[0]),
    .load      (ld[0]),
    .opa       (opa),
    .opb       (opb),
    .sum       (sum),
    .dec_in    (dec0),
    .dec_out   (dout0),
    .seg_out   (seg0),
    .digit_sel (sel0),
    .frame_done(fd0)
  );

  seg_scan_ctrl #(
    .DATA_WIDTH  (3),
    .RESULT_WIDTH(7),
    .PRESCALE    (1),
    .BLANK_CYCLES(0)
  ) u_dut1 (
    .clk       (clk),
    .rst       (rst[1]),
    .en        (en[1]),
    .load      (ld[1]),
    .opa       (opa),
    .opb       (opb),
    .sum       (sum),
    .dec_in    (dec1),
    .dec_out   (dout1),
    .seg_out   (seg1),
    .digit_sel (sel1),
    .frame_done(fd1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset(input int u);
    m_run[u]  = 1'b0;
    m_t[u]    = 0;
    m_pend[u] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      m_disp[u][k] = 3'd0;
      m_stg[u][k]  = 3'd0;
    end
  endtask

  task automatic model_edge(input int u);
    logic [2:0] nv [3];
    int         frame;
    bit         wrap;
    if (rst[u]) begin
      model_reset(u);
      return;
    end
    nv[0] = opa;
    nv[1] = opb;
    nv[2] = sum;
    frame = 3 * (pp[u] + bb[u]);
    wrap  = m_run[u] && en[u] && ((m_t[u] % frame) == frame - 1);
    if (!m_run[u]) begin
      for (int k = 0; k < 3; k++) m_disp[u][k] = m_stg[u][k];
      if (en[u]) begin
        m_run[u] = 1'b1;
        m_t[u]   = 0;
      end
    end else if (!en[u]) begin
      m_run[u] = 1'b0;
    end else begin
      m_t[u]++;
    end
    if (wrap) begin
      if (ld[u]) begin
        for (int k = 0; k < 3; k++) m_disp[u][k] = nv[k];
      end else if (m_pend[u]) begin
        for (int k = 0; k < 3; k++) m_disp[u][k] = m_stg[u][k];
      end
      m_pend[u] = 1'b0;
    end
    if (ld[u]) begin
      for (int k = 0; k < 3; k++) m_stg[u][k] = nv[k];
      if (!wrap) m_pend[u] = 1'b1;
    end
  endtask

  task automatic check_unit(input int u);
    int         slot, p, d, w;
    logic [2:0] e_sel, e_dec;
    logic [6:0] e_seg;
    logic       e_fd;
    slot  = pp[u] + bb[u];
    e_sel = 3'b000;
    e_seg = 7'd0;
    e_fd  = 1'b0;
    e_dec = m_disp[u][0];
    if (m_run[u]) begin
      p     = m_t[u] % (3 * slot);
      d     = p / slot;
      w     = p % slot;
      e_dec = m_disp[u][d];
      if (w >= bb[u]) begin
        e_sel = 3'(1 << d);
        e_seg = {4'b0000, m_disp[u][d]};
        e_fd  = (d == 2) && (w == slot - 1);
      end
    end
    chk($sformatf("u%0d_digit_sel", u), 32'(u == 0 ? sel0 : sel1), 32'(e_sel));
    chk($sformatf("u%0d_seg_out", u), 32'(u == 0 ? seg0 : seg1), 32'(e_seg));
    chk($sformatf("u%0d_frame_done", u), 32'(u == 0 ? fd0 : fd1), 32'(e_fd));
    chk($sformatf("u%0d_dec_in", u), 32'(u == 0 ? dec0 : dec1), 32'(e_dec));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge(0);
    model_edge(1);
    #1;
    check_unit(0);
    check_unit(1);
  endtask

  initial begin
    rst = 2'b11;
    en  = 2'b00;
    ld  = 2'b00;
    opa = 3'd0;
    opb = 3'd0;
    sum = 3'd0;
    model_reset(0);
    model_reset(1);
    #2;
    chk("reset_sel0", 32'(sel0), 32'd0);
    chk("reset_seg0", 32'(seg0), 32'd0);
    chk("reset_dec1", 32'(dec1), 32'd0);
    check_unit(0);
    check_unit(1);
    cyc();
    cyc();
    rst = 2'b00;

    // Idle with scan disabled: dark display.
    for (int i = 0; i < 20; i++) begin
      opa = 3'($urandom);
      opb = 3'($urandom);
      sum = 3'($urandom);
      cyc();
    end

    // Basic scan, tear-free update, load on the wrap edge, disable/re-enable.
    opa   = 3'd3;
    opb   = 3'd5;
    sum   = 3'd0;
    ld[0] = 1'b1;
    cyc();
    ld[0] = 1'b0;
    cyc();
    en[0] = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      cyc();
      if (i == 1)  chk("basic_blank_c1", 32'(sel0), 32'd0);
      if (i == 2)  chk("basic_d0_sel", 32'(sel0), 32'd1);
      if (i == 2)  chk("basic_d0_seg", 32'(seg0), 32'd3);
      if (i == 7)  chk("basic_d1_seg", 32'(seg0), 32'd5);
      if (i == 12) chk("basic_d2_sel", 32'(sel0), 32'd4);
      if (i == 14) chk("basic_no_fd", 32'(fd0), 32'd0);
      if (i == 15) chk("basic_fd_c15", 32'(fd0), 32'd1);
      if (i == 30) chk("basic_fd_c30", 32'(fd0), 32'd1);
      if (i == 40) chk("tear_d1_old", 32'(seg0), 32'd5);
      if (i == 43) chk("tear_d2_old", 32'(seg0), 32'd0);
      if (i == 48) chk("tear_d0_new", 32'(seg0), 32'd7);
      if (i == 53) chk("tear_d1_new", 32'(seg0), 32'd1);
      if (i == 58) chk("tear_d2_new", 32'(seg0), 32'd6);
      if (i == 63) chk("bypass_d0", 32'(seg0), 32'd2);
      if (i == 69) chk("dis_sel", 32'(sel0), 32'd0);
      if (i == 69) chk("dis_seg", 32'(seg0), 32'd0);
      if (i == 73) chk("reen_blank", 32'(sel0), 32'd0);
      if (i == 74) chk("reen_d0", 32'(sel0), 32'd1);
      opa   = 3'($urandom);
      opb   = 3'($urandom);
      sum   = 3'($urandom);
      ld[0] = 1'b0;
      if (i == 38) begin
        opa   = 3'd7;
        opb   = 3'd1;
        sum   = 3'd6;
        ld[0] = 1'b1;
      end
      if (i == 60) begin
        opa   = 3'd2;
        ld[0] = 1'b1;
      end
      if (i == 68) en[0] = 1'b0;
      if (i == 72) en[0] = 1'b1;
    end

    // No-blank, single-cycle digits on the second instance.
    en[0] = 1'b0;
    opa   = 3'd4;
    opb   = 3'd2;
    sum   = 3'd7;
    ld[1] = 1'b1;
    cyc();
    ld[1] = 1'b0;
    en[1] = 1'b1;
    for (int j = 1; j <= 12; j++) begin
      cyc();
      chk("fast_sel", 32'(sel1), 32'(1 << ((j - 1) % 3)));
      chk("fast_fd", 32'(fd1), 32'((j % 3) == 0));
    end

    // Asynchronous reset between edges.
    #3;
    rst[1] = 1'b1;
    #1;
    chk("arst_sel", 32'(sel1), 32'd0);
    chk("arst_seg", 32'(seg1), 32'd0);
    chk("arst_fd", 32'(fd1), 32'd0);
    chk("arst_dec", 32'(dec1), 32'd0);
    model_reset(1);
    cyc();
    cyc();
    rst[1] = 1'b0;

    // Randomized operation of both instances.
    for (int i = 0; i < 600; i++) begin
      for (int u = 0; u < 2; u++) begin
        en[u]  = ($urandom_range(0, 19) != 0);
        ld[u]  = ($urandom_range(0, 7) == 0);
        rst[u] = ($urandom_range(0, 199) == 0);
      end
      opa = 3'($urandom);
      opb = 3'($urandom);
      sum = 3'($urandom);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
